// File: rtl/pipeline_if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipeline_if_stage_pkg
// Description : Shared definitions for the instruction-fetch stage: FSM state
//               encoding, default reset PC, NOP encoding and PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_if_stage_pkg;

    // RUN   : normal fetching, responses are loaded into the slot.
    // DRAIN : a redirect arrived while a fetch was outstanding; the old
    //         request is held until its response arrives and is dropped.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage : pipeline_if_stage_pkg
`default_nettype wire

// File: rtl/pipeline_fetch_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_fetch_slot
// Description : One-entry {instruction, npc, valid} buffer between the fetch
//               logic and the IF/ID register. Flush has priority over load,
//               load has priority over consume. When empty the outputs show
//               NOP_INST / 0.
// Ports       : clock, reset          - clock, async active-high reset
//               flush_i               - drop the entry (redirect)
//               load_i                - capture load_inst_i / load_npc_i
//               consume_i             - entry taken downstream
//               inst_valid_o          - entry is live
//               instruction_o, npc_o  - entry contents (masked when empty)
//               load_misalign_i / misalign_o - only with IF_ALIGN_CHECK_EN
// Config      : IF_ALIGN_CHECK_EN adds the misalign flag to the entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_fetch_slot
    import pipeline_if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        consume_i,
    input  logic [31:0] load_inst_i,
    input  logic [31:0] load_npc_i,
`ifdef IF_ALIGN_CHECK_EN
    input  logic        load_misalign_i,
    output logic        misalign_o,
`endif
    output logic        inst_valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] npc_o
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q,  inst_d;
    logic [31:0] npc_q,   npc_d;
`ifdef IF_ALIGN_CHECK_EN
    logic        mis_q,   mis_d;
`endif

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        npc_d   = npc_q;
`ifdef IF_ALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = load_inst_i;
            npc_d   = load_npc_i;
`ifdef IF_ALIGN_CHECK_EN
            mis_d   = load_misalign_i;
`endif
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            npc_q   <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            npc_q   <= npc_d;
`ifdef IF_ALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Stale contents stay in the registers after consume; mask them here.
    assign inst_valid_o  = valid_q;
    assign instruction_o = valid_q ? inst_q : NOP_INST;
    assign npc_o         = valid_q ? npc_q  : 32'h0;
`ifdef IF_ALIGN_CHECK_EN
    assign misalign_o    = valid_q & mis_q;
`endif

endmodule : pipeline_fetch_slot
`default_nettype wire

// File: rtl/pipeline_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_if_stage
// Description : Instruction-fetch stage. Owns the PC, issues one-outstanding
//               fetches to instruction memory and buffers the fetched word in
//               a one-entry slot feeding the IF/ID register. A redirect
//               squashes the slot and any in-flight fetch (no delay slot).
// Ports       : clock, reset                 - clock, async active-high reset
//               pause                        - IF/ID stall
//               branch_signal, branch_target - redirect from ID
//               imem_req, imem_addr          - fetch request / address
//               imem_ready, imem_rdata       - same-cycle completion / data
//               npc_out, instruction_out     - slot contents to IF/ID
//               inst_valid                   - slot holds a live instruction
//               fetch_misalign               - only with IF_ALIGN_CHECK_EN
// Config      : IF_ALIGN_CHECK_EN - misaligned PC produces a flagged NOP and
//               freezes fetch until the next redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_if_stage
    import pipeline_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pause,
    input  logic        branch_signal,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] npc_out,
    output logic [31:0] instruction_out,
`ifdef IF_ALIGN_CHECK_EN
    output logic        fetch_misalign,
`endif
    output logic        inst_valid
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] target_q, target_d;

    logic        w_consume;
    logic        w_slot_free;
    logic        w_aligned;
    logic        w_slot_load;
    logic [31:0] w_load_inst;
    logic [31:0] w_load_npc;

    assign w_consume   = inst_valid & ~pause;
    // Slot can accept a word this cycle; this is also what keeps a held
    // request legal, since an empty slot cannot refill without completion.
    assign w_slot_free = ~inst_valid | w_consume;

`ifdef IF_ALIGN_CHECK_EN
    logic w_load_mis;
    logic halt_q, halt_d;   // set once the misaligned NOP has been issued
    assign w_aligned = (pc_q[1:0] == 2'b00);
    assign imem_addr = pc_q;
`else
    assign w_aligned = 1'b1;
    assign imem_addr = {pc_q[31:2], 2'b00};
`endif

    assign imem_req = ~reset & ((state_q == ST_DRAIN) | (w_slot_free & w_aligned));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        w_slot_load = 1'b0;
        w_load_inst = imem_rdata;
        w_load_npc  = pc_next(pc_q);
`ifdef IF_ALIGN_CHECK_EN
        w_load_mis  = 1'b0;
        halt_d      = branch_signal ? 1'b0 : halt_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (branch_signal) begin
                    if (imem_req && !imem_ready) begin
                        // Outstanding fetch must finish at its old address.
                        target_d = branch_target;
                        state_d  = ST_DRAIN;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (imem_req && imem_ready) begin
                    w_slot_load = 1'b1;
                    pc_d        = pc_next(pc_q);
                end
`ifdef IF_ALIGN_CHECK_EN
                else if (!w_aligned && !halt_q && w_slot_free) begin
                    w_slot_load = 1'b1;
                    w_load_inst = NOP_INST;
                    w_load_mis  = 1'b1;
                    halt_d      = 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                if (imem_ready) begin
                    // Response is dropped; a same-cycle branch is the newest target.
                    pc_d    = branch_signal ? branch_target : target_q;
                    state_d = ST_RUN;
                end else if (branch_signal) begin
                    target_d = branch_target;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            target_q <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
            halt_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
`ifdef IF_ALIGN_CHECK_EN
            halt_q   <= halt_d;
`endif
        end
    end

    pipeline_fetch_slot #(
        .NOP_INST (NOP_INST)
    ) u_slot (
        .clock           (clock),
        .reset           (reset),
        .flush_i         (branch_signal),
        .load_i          (w_slot_load),
        .consume_i       (w_consume),
        .load_inst_i     (w_load_inst),
        .load_npc_i      (w_load_npc),
`ifdef IF_ALIGN_CHECK_EN
        .load_misalign_i (w_load_mis),
        .misalign_o      (fetch_misalign),
`endif
        .inst_valid_o    (inst_valid),
        .instruction_o   (instruction_out),
        .npc_o           (npc_out)
    );

endmodule : pipeline_if_stage
`default_nettype wire

// File: tb/tb_pipeline_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_if_stage
// Description : Directed self-checking bench for pipeline_if_stage. Memory
//               model returns the fetch address as data. Inputs change and
//               outputs are sampled 1 time unit after the falling edge.
// Config      : IF_ALIGN_CHECK_EN selects the misalignment scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_if_stage;

    logic        clock;
    logic        reset;
    logic        pause;
    logic        branch_signal;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] npc_out;
    logic [31:0] instruction_out;
    logic        inst_valid;
`ifdef IF_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int errors = 0;
    int checks = 0;

    pipeline_if_stage dut (
        .clock           (clock),
        .reset           (reset),
        .pause           (pause),
        .branch_signal   (branch_signal),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .npc_out         (npc_out),
        .instruction_out (instruction_out),
`ifdef IF_ALIGN_CHECK_EN
        .fetch_misalign  (fetch_misalign),
`endif
        .inst_valid      (inst_valid)
    );

    assign imem_rdata = imem_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pause = 1'b0; branch_signal = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", inst_valid); end
        checks++; if (npc_out !== 32'h0) begin errors++; $display("FAIL rst_npc got=%h exp=00000000", npc_out); end
        checks++; if (instruction_out !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=00000000", instruction_out); end
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rel_addr got=%h exp=00400000", imem_addr); end
    endtask

    // Zero-wait streaming: one instruction per cycle, no gaps.
    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = 32'h0040_0000 + 32'(4 * i);
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, inst_valid); end
            checks++; if (instruction_out !== e) begin errors++; $display("FAIL b2b_inst[%0d] got=%h exp=%h", i, instruction_out, e); end
            checks++; if (npc_out !== e + 32'd4) begin errors++; $display("FAIL b2b_npc[%0d] got=%h exp=%h", i, npc_out, e + 32'd4); end
            checks++; if (imem_req !== 1'b1 || imem_addr !== e + 32'd4) begin errors++; $display("FAIL b2b_addr[%0d] got=%0h/%h exp=1/%h", i, imem_req, imem_addr, e + 32'd4); end
        end
    endtask

    // Memory holds ready low for three cycles on the fetch of 0x00400014.
    task automatic test_wait_states();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ws_valid[%0d] got=%0h exp=0", i, inst_valid); end
            checks++; if (instruction_out !== 32'h0) begin errors++; $display("FAIL ws_inst[%0d] got=%h exp=00000000", i, instruction_out); end
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0014) begin errors++; $display("FAIL ws_addr[%0d] got=%0h/%h exp=1/00400014", i, imem_req, imem_addr); end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0014) begin errors++; $display("FAIL ws_done got=%0h/%h exp=1/00400014", inst_valid, instruction_out); end
        checks++; if (npc_out !== 32'h0040_0018) begin errors++; $display("FAIL ws_npc got=%h exp=00400018", npc_out); end
    endtask

    // Stall with slot full: nothing moves, no request; release fetches at once.
    task automatic test_pause();
        pause = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pz_req0 got=%0h exp=0", imem_req); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0014 || npc_out !== 32'h0040_0018) begin
                errors++; $display("FAIL pz_hold[%0d] got=%0h/%h/%h exp=1/00400014/00400018", i, inst_valid, instruction_out, npc_out);
            end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pz_req[%0d] got=%0h exp=0", i, imem_req); end
        end
        pause = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0018) begin errors++; $display("FAIL pz_rel got=%0h/%h exp=1/00400018", imem_req, imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0018) begin errors++; $display("FAIL pz_next got=%0h/%h exp=1/00400018", inst_valid, instruction_out); end
    endtask

    // Redirect while the current fetch completes: its response is discarded.
    task automatic test_branch();
        branch_signal = 1'b1; branch_target = 32'h0040_0100;
        tick();
        branch_signal = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || instruction_out !== 32'h0) begin errors++; $display("FAIL br_squash got=%0h/%h exp=0/00000000", inst_valid, instruction_out); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL br_addr got=%0h/%h exp=1/00400100", imem_req, imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0100 || npc_out !== 32'h0040_0104) begin
            errors++; $display("FAIL br_first got=%0h/%h/%h exp=1/00400100/00400104", inst_valid, instruction_out, npc_out);
        end
    endtask

    // Two redirects while a fetch is outstanding: only the last target survives.
    task automatic test_pending_branch();
        imem_ready = 1'b0;
        tick();
        branch_signal = 1'b1; branch_target = 32'h0040_0200;
        tick();
        branch_signal = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0104) begin errors++; $display("FAIL pb_hold1 got=%0h/%h exp=1/00400104", imem_req, imem_addr); end
        branch_signal = 1'b1; branch_target = 32'h0040_0300;
        tick();
        branch_signal = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0104 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL pb_hold2 got=%0h/%h/%0h exp=1/00400104/0", imem_req, imem_addr, inst_valid);
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL pb_drop got=%0h exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0300) begin errors++; $display("FAIL pb_addr got=%0h/%h exp=1/00400300", imem_req, imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0300 || npc_out !== 32'h0040_0304) begin
            errors++; $display("FAIL pb_first got=%0h/%h/%h exp=1/00400300/00400304", inst_valid, instruction_out, npc_out);
        end
    endtask

    // Reset while draining returns to RUN at the reset PC; first word is kept.
    task automatic test_reset_drain();
        imem_ready = 1'b0;
        tick();
        branch_signal = 1'b1; branch_target = 32'h0040_0500;
        tick();
        branch_signal = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rd_rst got=%0h/%0h exp=0/0", imem_req, inst_valid); end
        tick();
        reset = 1'b0; imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rd_addr got=%0h/%h exp=1/00400000", imem_req, imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0000) begin errors++; $display("FAIL rd_first got=%0h/%h exp=1/00400000", inst_valid, instruction_out); end
    endtask

    // PC wrap at the top of the address space.
    task automatic test_wrap();
        branch_signal = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_signal = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got=%h exp=fffffffc", imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'hFFFF_FFFC || npc_out !== 32'h0) begin
            errors++; $display("FAIL wr_npc got=%0h/%h/%h exp=1/fffffffc/00000000", inst_valid, instruction_out, npc_out);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wr_next got=%0h/%h exp=1/00000000", imem_req, imem_addr); end
    endtask

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned target: flagged NOP, fetch frozen until the next redirect.
    task automatic test_misalign();
        branch_signal = 1'b1; branch_target = 32'h0040_0102;
        tick();
        branch_signal = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ma_req got=%0h exp=0", imem_req); end
        tick();
        checks++; if (inst_valid !== 1'b1 || fetch_misalign !== 1'b1 || instruction_out !== 32'h0) begin
            errors++; $display("FAIL ma_slot got=%0h/%0h/%h exp=1/1/00000000", inst_valid, fetch_misalign, instruction_out);
        end
        checks++; if (npc_out !== 32'h0040_0106 || imem_req !== 1'b0) begin errors++; $display("FAIL ma_npc got=%h/%0h exp=00400106/0", npc_out, imem_req); end
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ma_frozen got=%0h exp=0", imem_req); end
        branch_signal = 1'b1; branch_target = 32'h0040_0200;
        tick();
        branch_signal = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200 || fetch_misalign !== 1'b0) begin
            errors++; $display("FAIL ma_resume got=%0h/%h/%0h exp=1/00400200/0", imem_req, imem_addr, fetch_misalign);
        end
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0200 || fetch_misalign !== 1'b0) begin
            errors++; $display("FAIL ma_first got=%0h/%h/%0h exp=1/00400200/0", inst_valid, instruction_out, fetch_misalign);
        end
    endtask
`else
    // Without the check the low PC bits never reach the memory address.
    task automatic test_misalign();
        branch_signal = 1'b1; branch_target = 32'h0040_0102;
        tick();
        branch_signal = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL mask_addr got=%0h/%h exp=1/00400100", imem_req, imem_addr); end
        tick();
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h0040_0100) begin errors++; $display("FAIL mask_inst got=%0h/%h exp=1/00400100", inst_valid, instruction_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_pause();
        test_branch();
        test_pending_branch();
        test_reset_drain();
        test_wrap();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipeline_if_stage
`default_nettype wire
